greetings_top: RTL and testbench
================================

// Module: greetings_top
// PURPOSE
//  Greeting-message generator for the FPGA pseudo-terminal. Decodes the one-hot command
//  bus; on the GREET command, drives a 5-character ASCII window of a selected greeting
//  onto display, static or scrolling. Sits beside the other command units; display feeds
//  the terminal text/segment driver.
// PARAMETERS
//  SCROLL_DIV  4  clk cycles per scroll step (>=1)
//  GREET_BIT   5  op_code bit index meaning GREET
// PORTS
//  clk      in   1   system clock, rising edge
//  rst      in   1   asynchronous, active-high reset
//  a        in   8   operand: [2:0] message select, [7] scroll enable, [6:3] reserved/ignored
//  op_code  in  11   one-hot command bus
//  display  out 40   5 ASCII chars; char0 = [39:32] (leftmost) ... char4 = [7:0]
// BEHAVIOUR
//  - Single clock domain; one clock, reset is asynchronous and active-high.
//  - Reset: display = 40'h2020202020 (5 spaces), scroll pointer p = 0, divider cnt = 0.
//  - All outputs registered; display reflects inputs sampled at the previous rising edge
//    (1-cycle latency).
//  - GREET active iff op_code == (11'b1 << GREET_BIT) exactly. Zero, other bit, or multiple
//    bits set -> next cycle display = 5 spaces, p = 0, cnt = 0.
//  - Message ROM, 8 entries x 16 chars (space-padded), selected by a[2:0]:
//    0 "HELLO, WORLD!   " 1 "HOWDY PARTNER   " 2 "GOOD MORNING    "
//    3 "GOOD EVENING    " 4 "HI THERE        " 5 "WELCOME USER    "
//    6 "GREETINGS       " 7 "BONJOUR         "
//  - display char k = msg[(p + k) mod 16], k = 0..4 (window wraps end -> start).
//  - a[7]=0 (static): p held at 0, cnt = 0.
//  - a[7]=1 (scroll): cnt increments each cycle; when cnt == SCROLL_DIV-1, cnt <= 0 and
//    p <= (p+1) mod 16. p wraps 15 -> 0.
//  - a[2:0] differing from its value in the previous cycle -> p = 0, cnt = 0 this cycle
//    (new message always starts at char 0). Takes priority over a scroll step.
//  - a[7] falling 1->0 -> p = 0 immediately; rising 0->1 starts from p = 0, cnt = 0.
//  - Reset asserted mid-scroll -> outputs/state return to reset values at once, no clk needed.
//  - a[6:3] have no effect on any output.
// STRUCTURE
//  - Package greetings_pkg: GREET_BIT default, ASCII_SPACE = 8'h20, MSG_LEN = 16,
//    NUM_MSG = 8, message ROM contents as a constant array.
//  - Sub-module greetings_rom: combinational (msg_sel[2:0], char_idx[3:0]) -> ascii[7:0];
//    instantiated 5 times (one per window position) or time-shared via a generate loop.
//  - Top: op_code decode, prev-a[2:0] register, cnt/p counters, display register.
// TESTING
//  1. rst=1 -> display 40'h2020202020 without clock edge; stays after rst drops while op_code=0.
//  2. op_code=11'b00000100000, a=8'h00 -> after 1 clk display 40'h48454C4C4F ("HELLO").
//  3. Same op_code, a=8'h01 -> 40'h484F574459 ("HOWDY"); a=8'h07 -> "BONJO" 40'h424F4E4A4F.
//  4. a=8'h80, SCROLL_DIV=4: after 4 clks "ELLO," (40'h454C4C4F2C); at p=12 window
//     "!   H" (40'h2120202048); after 64 clks from start back to "HELLO".
//  5. op_code=11'b00001000000 or 11'b00000110000 -> next clk 5 spaces; restore GREET -> "HELLO".
//  6. a incrementing every 5 clks (8'h00..8'h8F) -> every a[2:0] change restarts at char 0;
//     async rst pulse mid-scroll -> blanks immediately, p=0 after release.

Source files
------------

// File: rtl/greetings_pkg.sv
// Shared constants and message ROM for the greeting generator.
// Messages are stored char0-first in the MSBs of each 128-bit row.
package greetings_pkg;

    localparam int GREET_BIT_DEF = 5;
    localparam int MSG_LEN       = 16;
    localparam int NUM_MSG       = 8;
    localparam int WIN_LEN       = 5;

    localparam logic [7:0] ASCII_SPACE = 8'h20;

    localparam logic [8*MSG_LEN-1:0] MSG_ROM [NUM_MSG] = '{
        "HELLO, WORLD!   ",
        "HOWDY PARTNER   ",
        "GOOD MORNING    ",
        "GOOD EVENING    ",
        "HI THERE        ",
        "WELCOME USER    ",
        "GREETINGS       ",
        "BONJOUR         "
    };

endpackage

// File: rtl/greetings_rom.sv
// Combinational message ROM lookup: one character per (message, index).
// Character 0 sits in the top byte of the row, so the index is inverted.
module greetings_rom
    import greetings_pkg::*;
(
    input  logic [2:0] i_msg_sel,
    input  logic [3:0] i_char_idx,
    output logic [7:0] o_ascii
);

    logic [8*MSG_LEN-1:0] w_row;
    logic [6:0]           w_bit;

    assign w_row   = MSG_ROM[i_msg_sel];
    assign w_bit   = {~i_char_idx, 3'b000};
    assign o_ascii = w_row[w_bit +: 8];

endmodule

// File: rtl/greetings_top.sv
// Greeting generator: decodes GREET and drives a 5-char window,
// static or scrolling, one cycle after the inputs are sampled.
module greetings_top
    import greetings_pkg::*;
#(
    parameter int SCROLL_DIV = 4,
    parameter int GREET_BIT  = GREET_BIT_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  a,
    input  logic [10:0] op_code,
    output logic [39:0] display
);

    localparam int CW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SCROLL_DIV - 1);
    localparam logic [10:0]   GREET_OP = 11'(1) << GREET_BIT;

    logic [3:0]    r_p;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_prev_sel;
    logic [39:0]   r_display;

    logic          w_greet;
    logic          w_restart;
    logic [3:0]    w_p_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic [39:0]   w_win;
    logic [39:0]   w_disp_nxt;
    logic [7:0]    w_chr [WIN_LEN];
    logic          w_unused;

    assign w_unused  = ^a[6:3];
    assign w_greet   = (op_code == GREET_OP);
    assign w_restart = !w_greet || !a[7] || (a[2:0] != r_prev_sel);

    // The window is built from the next pointer so the display
    // and the scroll state advance on the same edge.
    always_comb begin
        w_p_nxt   = r_p;
        w_cnt_nxt = r_cnt;
        if (w_restart) begin
            w_p_nxt   = 4'd0;
            w_cnt_nxt = '0;
        end else if (r_cnt == CNT_LAST) begin
            w_p_nxt   = r_p + 4'd1;
            w_cnt_nxt = '0;
        end else begin
            w_cnt_nxt = r_cnt + CW'(1);
        end
    end

    for (genvar k = 0; k < WIN_LEN; k++) begin : g_win
        logic [3:0] w_idx;
        assign w_idx = w_p_nxt + 4'(k);
        greetings_rom u_rom (
            .i_msg_sel  (a[2:0]),
            .i_char_idx (w_idx),
            .o_ascii    (w_chr[k])
        );
        assign w_win[8*(WIN_LEN-1-k) +: 8] = w_chr[k];
    end

    assign w_disp_nxt = w_greet ? w_win : {WIN_LEN{ASCII_SPACE}};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_p        <= 4'd0;
            r_cnt      <= '0;
            r_prev_sel <= 3'd0;
            r_display  <= {WIN_LEN{ASCII_SPACE}};
        end else begin
            r_p        <= w_p_nxt;
            r_cnt      <= w_cnt_nxt;
            r_prev_sel <= a[2:0];
            r_display  <= w_disp_nxt;
        end
    end

    assign display = r_display;

endmodule

// File: tb/tb_greetings_top.sv
// Randomized and directed bench for greetings_top against a
// string-based reference model of the greeting window.
module tb_greetings_top;

    localparam int          DIV   = 4;
    localparam logic [10:0] GREET = 11'b00000100000;
    localparam logic [39:0] BLANK = 40'h2020202020;

    logic        clk;
    logic        rst;
    logic [7:0]  a;
    logic [10:0] op_code;
    logic [39:0] display;

    int n_vec;
    int n_err;

    string msgs [8] = '{
        "HELLO, WORLD!   ", "HOWDY PARTNER   ",
        "GOOD MORNING    ", "GOOD EVENING    ",
        "HI THERE        ", "WELCOME USER    ",
        "GREETINGS       ", "BONJOUR         "
    };

    int          m_p;
    int          m_cnt;
    int          m_prev;
    logic [39:0] m_exp;

    greetings_top #(.SCROLL_DIV(DIV), .GREET_BIT(5)) dut (
        .clk     (clk),
        .rst     (rst),
        .a       (a),
        .op_code (op_code),
        .display (display)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [39:0] got,
                         input logic [39:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [39:0] window(input int sel, input int p);
        logic [39:0] w;
        w = '0;
        for (int k = 0; k < 5; k++)
            w[8*(4-k) +: 8] = msgs[sel][(p + k) % 16];
        return w;
    endfunction

    task automatic model_reset();
        m_p    = 0;
        m_cnt  = 0;
        m_prev = 0;
        m_exp  = BLANK;
    endtask

    task automatic model_step(input logic [10:0] op_i,
                              input logic [7:0] a_i);
        bit greet;
        int sel;
        greet = (op_i == GREET);
        sel   = int'(a_i[2:0]);
        if (!greet || !a_i[7] || sel != m_prev) begin
            m_p   = 0;
            m_cnt = 0;
        end else if (m_cnt == DIV - 1) begin
            m_cnt = 0;
            m_p   = (m_p + 1) % 16;
        end else begin
            m_cnt = m_cnt + 1;
        end
        m_prev = sel;
        m_exp  = greet ? window(sel, m_p) : BLANK;
    endtask

    task automatic apply(input logic [10:0] op_i,
                         input logic [7:0] a_i);
        op_code = op_i;
        a       = a_i;
        @(posedge clk);
        model_step(op_i, a_i);
        @(negedge clk);
        check("model", display, m_exp);
    endtask

    initial begin
        logic [7:0]  ra;
        logic [10:0] rop;
        n_vec   = 0;
        n_err   = 0;
        rst     = 1'b0;
        a       = 8'h00;
        op_code = 11'h000;
        model_reset();

        #1 rst = 1'b1;
        #2 check("rst_async", display, BLANK);
        @(negedge clk);
        check("rst_hold", display, BLANK);
        rst = 1'b0;
        apply(11'h000, 8'h00);
        check("idle", display, BLANK);

        apply(GREET, 8'h00);
        check("hello", display, 40'h48454C4C4F);
        apply(GREET, 8'h01);
        check("howdy", display, 40'h484F574459);
        apply(GREET, 8'h07);
        check("bonjo", display, 40'h424F4E4A4F);
        apply(GREET, 8'h00);

        for (int i = 1; i <= 64; i++) begin
            apply(GREET, 8'h80);
            if (i == 4)  check("scr4", display, 40'h454C4C4F2C);
            if (i == 48) check("scr48", display, 40'h2120202048);
            if (i == 64) check("scr64", display, 40'h48454C4C4F);
        end

        apply(11'b00001000000, 8'h00);
        check("othr_bit", display, BLANK);
        apply(GREET, 8'h00);
        check("restore1", display, 40'h48454C4C4F);
        apply(11'b00000110000, 8'h00);
        check("multi_bit", display, BLANK);
        apply(GREET, 8'h00);
        check("restore2", display, 40'h48454C4C4F);

        for (int v = 0; v <= 8'h8F; v++) begin
            for (int c = 0; c < 5; c++) begin
                apply(GREET, 8'(v));
                if (c == 0 && v[2:0] != 3'(v - 1))
                    check("restart", display, window(v % 8, 0));
                if (v == 8'h8D && c == 2) begin
                    rst = 1'b1;
                    #1 check("rst_mid", display, BLANK);
                    model_reset();
                    #2 rst = 1'b0;
                end
            end
        end

        ra = 8'h80;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(7) == 0)
                ra = 8'($urandom);
            ra[6:3] = 4'($urandom);
            case ($urandom_range(9))
                0: rop = 11'($urandom);
                1: rop = 11'(1) << $urandom_range(10);
                default: rop = GREET;
            endcase
            apply(rop, ra);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
